mat_mul_host_ctrl: RTL and testbench

// Host-side initiator for the matrix_multiplication memory/compute interface. Accepts a job as a
// row stream (MAT_MUL_SIZE rows of A, then MAT_MUL_SIZE rows of B) and writes them through

---
 rtl/mat_mul_host_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mat_mul_host_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_host_ctrl.sv
// Host-side initiator for the matrix_multiplication datapath: loads A/B rows, runs compute, reads C into a FIFO.
// Optional compute watchdog enabled by defining MAT_HOST_CTRL_TIMEOUT_EN.
module mat_mul_host_ctrl #(
  parameter int DWIDTH         = 8,
  parameter int AWIDTH         = 7,
  parameter int MAT_MUL_SIZE   = 4,
  parameter int WR_LAT         = 2,
  parameter int RD_LAT         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           busy,
  output logic                           job_done,
  output logic                           timeout_err,
  output logic                           enable_writing_to_mem,
  output logic                           enable_reading_from_mem,
  output logic [AWIDTH-1:0]              addr_pi,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
  output logic                           we_a,
  output logic                           we_b,
  output logic                           we_c,
  output logic                           start_mat_mul,
  input  logic                           done_mat_mul,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
);
  localparam int RW  = MAT_MUL_SIZE * DWIDTH;
  localparam int IW  = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;
  localparam int CW  = $clog2(MAT_MUL_SIZE + 1);
  localparam int DRW = (WR_LAT > 0) ? $clog2(WR_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WR_DRAIN, S_COMPUTE, S_READ_C, S_FLUSH
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     row_q;
  logic [AWIDTH-1:0] addr_q;
  logic              busy_q;
  logic [DRW-1:0]    drain_q;
  logic [IW-1:0]     rd_idx_q;
  logic [CW-1:0]     rd_out_q;
  logic [IW-1:0]     pop_cnt_q;

  logic [WR_LAT:0]         wr_vld_pipe;
  logic [WR_LAT:0]         wr_isb_pipe;
  logic [WR_LAT:0][RW-1:0] wr_data_pipe;
  logic [RD_LAT:0]         rd_vld_pipe;

  logic [RW-1:0] fifo_q [MAT_MUL_SIZE];
  logic [IW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  logic          acc, push, pop, issue, last_row;
  logic [CW:0]   credit_used;

  assign in_ready    = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign acc         = in_valid && in_ready;
  assign last_row    = (row_q == IW'(MAT_MUL_SIZE - 1));
  assign push        = rd_vld_pipe[RD_LAT];
  assign pop         = out_valid && out_ready;
  // Reads in flight plus rows already buffered may never exceed FIFO depth.
  assign credit_used = {1'b0, rd_out_q} + {1'b0, cnt_q};
  assign issue       = (state_q == S_READ_C) && (credit_used < (CW+1)'(MAT_MUL_SIZE));

  assign enable_writing_to_mem   = in_ready || (state_q == S_WR_DRAIN);
  assign enable_reading_from_mem = (state_q == S_READ_C) || (state_q == S_FLUSH);
  assign start_mat_mul           = (state_q == S_COMPUTE);
  assign we_c                    = (state_q == S_COMPUTE);
  assign addr_pi                 = addr_q;
  assign data_pi                 = wr_data_pipe[WR_LAT];
  assign we_a                    = wr_vld_pipe[WR_LAT] && !wr_isb_pipe[WR_LAT];
  assign we_b                    = wr_vld_pipe[WR_LAT] &&  wr_isb_pipe[WR_LAT];
  assign busy                    = busy_q;
  assign out_valid               = (cnt_q != '0);
  assign out_data                = fifo_q[rptr_q];
  assign job_done                = pop && (pop_cnt_q == IW'(MAT_MUL_SIZE - 1));

`ifdef MAT_HOST_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      drain_q   <= '0;
      rd_idx_q  <= '0;
      rd_out_q  <= '0;
      pop_cnt_q <= '0;
`ifdef MAT_HOST_CTRL_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q <= S_LOAD_A;
            row_q   <= '0;
          end
        end
        S_LOAD_A: begin
          if (acc) begin
            addr_q <= AWIDTH'(row_q);
            busy_q <= 1'b1;
            if (last_row) begin
              row_q   <= '0;
              state_q <= S_LOAD_B;
            end else begin
              row_q <= row_q + IW'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (acc) begin
            addr_q <= AWIDTH'(row_q);
            if (last_row) begin
              row_q   <= '0;
              drain_q <= '0;
              state_q <= S_WR_DRAIN;
            end else begin
              row_q <= row_q + IW'(1);
            end
          end
        end
        S_WR_DRAIN: begin
          if (drain_q == DRW'(WR_LAT)) begin
            state_q <= S_COMPUTE;
`ifdef MAT_HOST_CTRL_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end else begin
            drain_q <= drain_q + DRW'(1);
          end
        end
        S_COMPUTE: begin
          if (done_mat_mul) begin
            state_q  <= S_READ_C;
            rd_idx_q <= '0;
          end
`ifdef MAT_HOST_CTRL_TIMEOUT_EN
          else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
`endif
        end
        S_READ_C: begin
          if (issue) begin
            addr_q   <= AWIDTH'(rd_idx_q);
            rd_idx_q <= rd_idx_q + IW'(1);
            if (rd_idx_q == IW'(MAT_MUL_SIZE - 1)) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (job_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (pop) pop_cnt_q <= job_done ? '0 : pop_cnt_q + IW'(1);
      rd_out_q <= rd_out_q + CW'(issue) - CW'(push);
    end
  end

  // Write delay line: addr_pi leads data_pi/we_x by WR_LAT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_pipe  <= '0;
      wr_isb_pipe  <= '0;
      wr_data_pipe <= '0;
      rd_vld_pipe  <= '0;
    end else begin
      wr_vld_pipe[0]  <= acc;
      wr_isb_pipe[0]  <= (state_q == S_LOAD_B);
      wr_data_pipe[0] <= in_data;
      for (int i = 1; i <= WR_LAT; i++) begin
        wr_vld_pipe[i]  <= wr_vld_pipe[i-1];
        wr_isb_pipe[i]  <= wr_isb_pipe[i-1];
        wr_data_pipe[i] <= wr_data_pipe[i-1];
      end
      rd_vld_pipe <= {rd_vld_pipe[RD_LAT-1:0], issue};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAT_MUL_SIZE; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= data_from_out_mat;
        wptr_q <= (wptr_q == IW'(MAT_MUL_SIZE - 1)) ? '0 : wptr_q + IW'(1);
      end
      if (pop) rptr_q <= (rptr_q == IW'(MAT_MUL_SIZE - 1)) ? '0 : rptr_q + IW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_mat_mul_host_ctrl.sv
// Scoreboard bench for mat_mul_host_ctrl with a behavioural datapath model (memories, multiply, read latency).
module tb_mat_mul_host_ctrl;
  localparam int RD_LAT  = 4;
  localparam int DONE_AT = 20;
  localparam int TMO     = 64;

  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] in_data = 0, out_data, data_pi, data_from_out_mat;
  logic        busy, job_done, timeout_err, en_wr, en_rd, we_a, we_b, we_c, start_mat_mul;
  logic        done_mat_mul = 0;
  logic [6:0]  addr_pi;

  always #5 clk = ~clk;

  mat_mul_host_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .job_done(job_done), .timeout_err(timeout_err), .enable_writing_to_mem(en_wr),
    .enable_reading_from_mem(en_rd), .addr_pi(addr_pi), .data_pi(data_pi), .we_a(we_a),
    .we_b(we_b), .we_c(we_c), .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
    .data_from_out_mat(data_from_out_mat));

  int checks = 0, failures = 0;
  logic [40:0] wq [$];
  logic [31:0] oq [$];
  int jd_cnt = 0, exp_jd = 0, job_req = 0, job_seen = 0, tmo_req = 0, tmo_seen = 0;
  int mon_rows = 0, hi_cnt = 0;
  bit done_en = 1;

  // Datapath model: addr_pi history, A/B memories, C result rows.
  logic [6:0]  hist [RD_LAT];
  logic [31:0] a_mem [4], b_mem [4], c_mem [4];
  always @(posedge clk) begin
    if (we_a) a_mem[hist[1][1:0]] <= data_pi;
    if (we_b) b_mem[hist[1][1:0]] <= data_pi;
    hist[0] <= addr_pi;
    for (int k = 1; k < RD_LAT; k++) hist[k] <= hist[k-1];
  end
  assign data_from_out_mat = c_mem[hist[RD_LAT-1][1:0]];

  function automatic logic [31:0] crow(input int i);
    logic [31:0] r;
    logic [7:0]  s;
    r = 0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s = s + 8'(a_mem[i][k*8+:8] * b_mem[k][j*8+:8]);
      r[j*8+:8] = s;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [40:0] we_exp;
    logic [31:0] o_exp;
    if (reset) begin
      checks++;
      if ({in_ready, out_valid, busy, job_done, timeout_err, en_wr, en_rd, we_a, we_b, we_c,
           start_mat_mul} != 11'd0 || addr_pi != 0 || data_pi != 0 || out_data != 0) begin
        failures++;
        $display("FAIL reset_outputs: ctl=%b addr=%0d data=%h out=%h required all zero",
                 {in_ready, out_valid, busy, job_done, timeout_err, en_wr, en_rd, we_a, we_b, we_c,
                  start_mat_mul}, addr_pi, data_pi, out_data);
      end
      wq.delete(); oq.delete(); mon_rows = 0; hi_cnt = 0; done_mat_mul = 0;
    end else begin
      if (we_a || we_b) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL write_spurious: we_a=%b we_b=%b addr=%0d data=%h required no write", we_a, we_b, hist[1], data_pi);
        end else begin
          we_exp = wq.pop_front();
          if ({we_a, we_b, hist[1], data_pi} != we_exp) begin
            failures++;
            $display("FAIL write_event: got we_a=%b we_b=%b addr=%0d data=%h required %b %b %0d %h",
                     we_a, we_b, hist[1], data_pi, we_exp[40], we_exp[39], we_exp[38:32], we_exp[31:0]);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        o_exp = (oq.size() != 0) ? oq.pop_front() : 32'hDEADBEEF;
        if (out_data != o_exp || job_done != (mon_rows == 3)) begin
          failures++;
          $display("FAIL out_row%0d: data=%h job_done=%b required %h %b", mon_rows, out_data, job_done, o_exp, mon_rows == 3);
        end
        if (job_done) jd_cnt++;
        mon_rows = (mon_rows == 3) ? 0 : mon_rows + 1;
      end else if (job_done) begin
        checks++; failures++;
        $display("FAIL job_done_stray: job_done=1 required 0 without final handshake");
      end
      if (start_mat_mul) begin
        hi_cnt++;
        if (hi_cnt == 1) for (int i = 0; i < 4; i++) c_mem[i] = crow(i);
        done_mat_mul = done_en && (hi_cnt == DONE_AT);
      end else begin
        if (hi_cnt != 0) begin
          checks++;
          if (hi_cnt != (done_en ? DONE_AT : TMO) || we_c) begin
            failures++;
            $display("FAIL start_len: cycles=%0d we_c=%b required %0d 0", hi_cnt, we_c, done_en ? DONE_AT : TMO);
          end
        end
        hi_cnt = 0;
        done_mat_mul = 0;
      end
    end
    if (job_req != job_seen) begin
      job_seen = job_req;
      checks++;
      if (jd_cnt != exp_jd || busy || wq.size() != 0 || oq.size() != 0) begin
        failures++;
        $display("FAIL job_end: job_done_count=%0d busy=%b wq=%0d oq=%0d required %0d 0 0 0",
                 jd_cnt, busy, wq.size(), oq.size(), exp_jd);
      end
    end
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      checks++;
      if (start_mat_mul || !timeout_err || busy || jd_cnt != exp_jd) begin
        failures++;
        $display("FAIL timeout_state: start=%b timeout_err=%b busy=%b jd=%0d required 0 1 0 %0d",
                 start_mat_mul, timeout_err, busy, jd_cnt, exp_jd);
      end
    end
  end

  task automatic send_row(input logic [31:0] d, input logic isb, input int idx);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_data = d;
    while (!in_ready) begin
      @(negedge clk);
      if (++n > 100) begin $display("FAIL send_row_timeout idx=%0d", idx); $fatal(1); end
    end
    wq.push_back({~isb, isb, 7'(idx), d});
    @(posedge clk);
  endtask

  task automatic gap_cycles(input int n);
    @(negedge clk); in_valid = 0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_until_rd();
    int n = 0;
    while (!en_rd) begin
      @(negedge clk);
      if (++n > 500) begin $display("FAIL wait_read_timeout"); $fatal(1); end
    end
  endtask

  task automatic load_rows(input logic [31:0] a[4], input logic [31:0] b[4], input int gap);
    for (int i = 0; i < 4; i++) begin send_row(a[i], 0, i); if (gap > 0) gap_cycles(gap); end
    for (int i = 0; i < 4; i++) begin send_row(b[i], 1, i); if (gap > 0 && i < 3) gap_cycles(gap); end
    @(negedge clk); in_valid = 0;
  endtask

  task automatic run_job(input logic [31:0] a[4], input logic [31:0] b[4], input logic [31:0] c[4],
                         input int gap, input int stall);
    int n = 0;
    @(negedge clk);
    out_ready = (stall == 0);
    for (int i = 0; i < 4; i++) oq.push_back(c[i]);
    load_rows(a, b, gap);
    if (stall > 0) begin
      wait_until_rd();
      repeat (stall) @(negedge clk);
      out_ready = 1;
    end
    while (jd_cnt != exp_jd + 1) begin
      @(negedge clk);
      if (++n > 2000) begin $display("FAIL job_done_timeout"); $fatal(1); end
    end
    exp_jd++;
    @(negedge clk);
    job_req++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1; in_valid = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 0; out_ready = 1;
  endtask

  logic [31:0] a1[4] = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
  logic [31:0] b1[4] = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
  logic [31:0] c1[4] = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
  logic [31:0] a2[4] = '{32'h04030201, 32'h08070605, 32'h40302010, 32'hFF000000};
  logic [31:0] b2[4] = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
  logic [31:0] c2[4] = '{32'h0A0A0A0A, 32'h1A1A1A1A, 32'hA0A0A0A0, 32'hFFFFFFFF};

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 0;
    run_job(a1, b1, c1, 0, 0);
    run_job(a2, b2, c2, 3, 0);
    run_job(a1, b1, c1, 0, 10);
    // Abort mid-LOAD_B, then a clean job.
    for (int i = 0; i < 4; i++) send_row(a2[i], 0, i);
    for (int i = 0; i < 2; i++) send_row(b2[i], 1, i);
    do_reset();
    run_job(a2, b2, c2, 0, 0);
    // Abort mid-READ_C, then a clean job.
    @(negedge clk);
    for (int i = 0; i < 4; i++) oq.push_back(c1[i]);
    load_rows(a1, b1, 0);
    wait_until_rd();
    @(negedge clk);
    do_reset();
    run_job(a1, b1, c1, 0, 0);
`ifdef MAT_HOST_CTRL_TIMEOUT_EN
    begin
      int n = 0;
      done_en = 0;
      load_rows(a2, b2, 0);
      @(negedge clk);
      while (busy) begin
        @(negedge clk);
        if (++n > 500) begin $display("FAIL timeout_wait"); $fatal(1); end
      end
      @(negedge clk);
      tmo_req++;
      repeat (2) @(negedge clk);
      done_en = 1;
      do_reset();
    end
`endif
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
